om_range_buffer: RTL and testbench
==================================

Name: om_range_buffer

Overview:
- Storage stage directly downstream of the heap-overflow tracker.
- Holds up to DEPTH detected overflow address ranges as a circular buffer; each range is [first, last], inclusive, byte addresses.
- Answers a combinational "is this address inside any recorded range" query that the tracker uses in the same cycle to flag loads.
- Exposes the newest range for debug and CSR readout.

Parameters:
- DEPTH, 8, number of range slots; must be a power of two, minimum 2.
- ADDR_W, 32, width of range bounds and query address.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all entries (software/user reset).
- en_write_i  in  1  one-cycle write strobe for a new range.
- addr_first_i  in  ADDR_W  first byte address of the new range.
- addr_last_i  in  ADDR_W  last byte address of the new range.
- find_addr_i  in  ADDR_W  query address.
- addr_in_range_o  out  1  query address lies inside a valid entry.
- hit_idx_o  out  $clog2(DEPTH)  lowest-index matching slot; 0 when no hit.
- read_o  out  ADDR_W  first bound of the newest entry.
- read2_o  out  ADDR_W  last bound of the newest entry.
- count_o  out  $clog2(DEPTH)+1  number of valid entries.
- full_o  out  1  count_o == DEPTH.
- overwrite_o  out  1  one-cycle pulse when the oldest entry was replaced.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All valid bits, wr_ptr, count and overwrite are cleared; entry contents are zeroed.
  - Outputs: addr_in_range_o=0, hit_idx_o=0, read_o=0, read2_o=0, count_o=0, full_o=0, overwrite_o=0.
- clear_i:
  - Same effect as reset, on the next clock edge.
  - Clear wins over a simultaneous write; that write is discarded.
- Write acceptance:
  - Sampled on a clock edge when en_write_i=1 and clear_i=0.
  - A write with addr_first_i > addr_last_i (unsigned) is malformed and silently dropped; no state change.
- Merge rule:
  - Applies when count>0 and addr_first_i == newest.last + 1 (ADDR_W wrap-around disallowed: newest.last == all-ones never merges).
  - newest.last becomes addr_last_i; wr_ptr and count are unchanged.
- Normal append:
  - Slot[wr_ptr] <= {first, last}, valid set, wr_ptr <= wr_ptr+1 mod DEPTH.
  - If count < DEPTH: count increments.
  - Else: the oldest entry (the one at wr_ptr) is overwritten, count stays DEPTH, and overwrite_o=1 for exactly the following cycle.
- Newest entry: slot[wr_ptr-1 mod DEPTH]. read_o/read2_o are registered views of it, updated the cycle after a write or merge.
- Lookup:
  - Purely combinational, zero latency.
  - Hit on slot i when valid[i] && first[i] <= find_addr_i <= last[i] (unsigned, inclusive).
  - A write on edge N is visible to lookups from cycle N+1; a same-cycle query sees the old contents.
- Multiple hits: addr_in_range_o=1 and hit_idx_o = lowest matching index.
- No backpressure: every write is accepted in one cycle; the upstream stage never stalls.

Decomposition:
- om_pkg:
  - om_range_t struct {first, last} of ADDR_W each.
  - OM_DEPTH default.
  - Helper function om_in_range(range, addr).
- om_range_cmp sub-module: one per slot, inputs valid/range/addr, output hit. Generated DEPTH times; the priority encoder for hit_idx_o lives in the top.

Test Plan:
- Reset then query 0x8000_0010 -> addr_in_range_o=0, count_o=0, read_o=0, full_o=0.
- Write [0x8000_0100, 0x8000_0127]; next cycle query 0x8000_0127 -> hit=1, hit_idx_o=0; query 0x8000_0128 -> hit=0; read_o=0x8000_0100, read2_o=0x8000_0127, count_o=1.
- Write [0x8000_0128, 0x8000_0140] after the above -> merge: count_o stays 1, read2_o=0x8000_0140, query 0x8000_0130 hits.
- Nine non-adjacent writes with DEPTH=8, base 0x8000_1000 + k*0x100, length 0x20 -> after the 9th: count_o=8, full_o=1, overwrite_o pulses one cycle, query 0x8000_1010 misses, query 0x8000_1810 hits at hit_idx_o=0.
- Write [0x8000_0200, 0x8000_01FF] -> dropped, count_o unchanged. Then clear_i and en_write_i asserted in the same cycle -> count_o=0, all queries miss.
- Assert rst_ni low mid-sequence with 3 entries valid -> all outputs 0 immediately, without waiting for a clock edge; after release, a new write lands in slot 0.

Source files
------------

// File: rtl/om_range_buffer_pkg.sv
// rtl/om_range_buffer_pkg.sv - shared range type, defaults and range test helper
package om_pkg;

    localparam int OM_DEPTH  = 8;
    localparam int OM_ADDR_W = 32;

    // Inclusive byte-address range [first, last]
    typedef struct packed {
        logic [OM_ADDR_W-1:0] first;
        logic [OM_ADDR_W-1:0] last;
    } om_range_t;

    // Unsigned, inclusive at both ends
    function automatic logic om_in_range(om_range_t r, logic [OM_ADDR_W-1:0] addr);
        return (addr >= r.first) && (addr <= r.last);
    endfunction

endpackage

// File: rtl/om_range_buffer_if.sv
// rtl/om_range_buffer_if.sv - write/query/status bundle between tracker and range buffer
interface om_range_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              clear_i;
    logic              en_write_i;
    logic [ADDR_W-1:0] addr_first_i;
    logic [ADDR_W-1:0] addr_last_i;
    logic [ADDR_W-1:0] find_addr_i;
    logic              addr_in_range_o;
    logic [IDX_W-1:0]  hit_idx_o;
    logic [ADDR_W-1:0] read_o;
    logic [ADDR_W-1:0] read2_o;
    logic [IDX_W:0]    count_o;
    logic              full_o;
    logic              overwrite_o;

    modport master (
        output clear_i, en_write_i, addr_first_i, addr_last_i, find_addr_i,
        input  addr_in_range_o, hit_idx_o, read_o, read2_o, count_o, full_o, overwrite_o
    );

    modport slave (
        input  clear_i, en_write_i, addr_first_i, addr_last_i, find_addr_i,
        output addr_in_range_o, hit_idx_o, read_o, read2_o, count_o, full_o, overwrite_o
    );

endinterface

// File: rtl/om_range_buffer_cmp.sv
// rtl/om_range_buffer_cmp.sv - per-slot range comparator
module om_range_cmp
    import om_pkg::*;
(
    input  logic                 valid,
    input  om_range_t            bounds,
    input  logic [OM_ADDR_W-1:0] addr,
    output logic                 hit
);

    assign hit = valid && om_in_range(bounds, addr);

endmodule

// File: rtl/om_range_buffer.sv
// rtl/om_range_buffer.sv - circular buffer of overflow ranges with combinational lookup
module om_range_buffer
    import om_pkg::*;
#(
    parameter int DEPTH  = OM_DEPTH,
    parameter int ADDR_W = OM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    om_range_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    om_range_t         slot_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overwrite_q;
    logic [ADDR_W-1:0] read_q;
    logic [ADDR_W-1:0] read2_q;

    logic [PTR_W-1:0]     newest_idx;
    om_range_t            newest;
    om_range_t            wr_range;
    logic [OM_ADDR_W-1:0] query;
    logic                 full;
    logic                 wr_ok;
    logic                 merge;
    logic [DEPTH-1:0]     hit_vec;
    logic [PTR_W-1:0]     hit_idx;

    // Newest slot sits just behind the write pointer (power-of-two wrap)
    assign newest_idx     = wr_ptr_q - PTR_W'(1);
    assign newest         = slot_q[newest_idx];
    assign wr_range.first = OM_ADDR_W'(bus.addr_first_i);
    assign wr_range.last  = OM_ADDR_W'(bus.addr_last_i);
    assign query          = OM_ADDR_W'(bus.find_addr_i);
    assign full           = (count_q == CNT_W'(DEPTH));

    // Malformed ranges are dropped; merging never crosses the top of the address space
    assign wr_ok = bus.en_write_i && !bus.clear_i && (wr_range.first <= wr_range.last);
    assign merge = wr_ok && (count_q != '0) && (newest.last != '1)
                && (wr_range.first == newest.last + OM_ADDR_W'(1));

    // Slot storage, pointers, count and registered newest-entry view
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overwrite_q <= 1'b0;
            read_q      <= '0;
            read2_q     <= '0;
        end else if (bus.clear_i) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overwrite_q <= 1'b0;
            read_q      <= '0;
            read2_q     <= '0;
        end else begin
            overwrite_q <= 1'b0;
            if (merge) begin
                slot_q[newest_idx].last <= wr_range.last;
                read2_q                 <= ADDR_W'(wr_range.last);
            end else if (wr_ok) begin
                slot_q[wr_ptr_q]  <= wr_range;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
                if (!full) count_q <= count_q + CNT_W'(1);
                overwrite_q       <= full;
                read_q            <= ADDR_W'(wr_range.first);
                read2_q           <= ADDR_W'(wr_range.last);
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        om_range_cmp u_cmp (
            .valid  (valid_q[g]),
            .bounds (slot_q[g]),
            .addr   (query),
            .hit    (hit_vec[g])
        );
    end

    // Lowest matching slot wins
    always_comb begin
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = PTR_W'(i);
        end
    end

    assign bus.addr_in_range_o = |hit_vec;
    assign bus.hit_idx_o       = hit_idx;
    assign bus.read_o          = read_q;
    assign bus.read2_o         = read2_q;
    assign bus.count_o         = count_q;
    assign bus.full_o          = full;
    assign bus.overwrite_o     = overwrite_q;

endmodule

// File: tb/tb_om_range_buffer.sv
// tb/tb_om_range_buffer.sv - scoreboard bench for om_range_buffer
module tb_om_range_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    om_range_buffer_if #(.DEPTH(8), .ADDR_W(32)) bus ();

    om_range_buffer #(.DEPTH(8), .ADDR_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic [2:0]  idx;
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [3:0]  cnt;
        logic        full;
        logic        ovw;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp(e.name, "hit",   32'(bus.addr_in_range_o), 32'(e.hit));
                cmp(e.name, "idx",   32'(bus.hit_idx_o),       32'(e.idx));
                cmp(e.name, "read",  bus.read_o,               e.rd);
                cmp(e.name, "read2", bus.read2_o,              e.rd2);
                cmp(e.name, "count", 32'(bus.count_o),         32'(e.cnt));
                cmp(e.name, "full",  32'(bus.full_o),          32'(e.full));
                cmp(e.name, "ovw",   32'(bus.overwrite_o),     32'(e.ovw));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] f, input logic [31:0] l);
        bus.en_write_i   = 1'b1;
        bus.addr_first_i = f;
        bus.addr_last_i  = l;
        cyc();
        bus.en_write_i   = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] q, input logic hit, input logic [2:0] idx,
                       input logic [31:0] rd, input logic [31:0] rd2, input logic [3:0] cnt,
                       input logic full, input logic ovw);
        exp_t e;
        bus.find_addr_i = q;
        e.name = nm; e.hit = hit; e.idx = idx; e.rd = rd; e.rd2 = rd2;
        e.cnt = cnt; e.full = full; e.ovw = ovw;
        sbq.push_back(e);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.clear_i      = 1'b0;
        bus.en_write_i   = 1'b0;
        bus.addr_first_i = '0;
        bus.addr_last_i  = '0;
        bus.find_addr_i  = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        chk("reset", 32'h8000_0010, 0, 0, 0, 0, 0, 0, 0);

        wr(32'h8000_0100, 32'h8000_0127);
        chk("w1_last", 32'h8000_0127, 1, 0, 32'h8000_0100, 32'h8000_0127, 1, 0, 0);
        chk("w1_past", 32'h8000_0128, 0, 0, 32'h8000_0100, 32'h8000_0127, 1, 0, 0);

        wr(32'h8000_0128, 32'h8000_0140);
        chk("merge_mid", 32'h8000_0130, 1, 0, 32'h8000_0100, 32'h8000_0140, 1, 0, 0);
        chk("merge_end", 32'h8000_0140, 1, 0, 32'h8000_0100, 32'h8000_0140, 1, 0, 0);

        bus.clear_i = 1'b1;
        cyc();
        bus.clear_i = 1'b0;
        chk("clear", 32'h8000_0130, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 8; k++) wr(32'h8000_1000 + k * 32'h100, 32'h8000_101F + k * 32'h100);
        chk("eight_full", 32'h8000_1710, 1, 7, 32'h8000_1700, 32'h8000_171F, 8, 1, 0);
        wr(32'h8000_1800, 32'h8000_181F);
        chk("ovw_miss",  32'h8000_1010, 0, 0, 32'h8000_1800, 32'h8000_181F, 8, 1, 1);
        chk("ovw_hit",   32'h8000_1810, 1, 0, 32'h8000_1800, 32'h8000_181F, 8, 1, 0);
        chk("slot1",     32'h8000_1110, 1, 1, 32'h8000_1800, 32'h8000_181F, 8, 1, 0);
        chk("slot7_end", 32'h8000_171F, 1, 7, 32'h8000_1800, 32'h8000_181F, 8, 1, 0);
        chk("slot7_gap", 32'h8000_1720, 0, 0, 32'h8000_1800, 32'h8000_181F, 8, 1, 0);

        wr(32'h8000_0200, 32'h8000_01FF);
        chk("malformed", 32'h8000_0200, 0, 0, 32'h8000_1800, 32'h8000_181F, 8, 1, 0);

        wr(32'h8000_1000, 32'h8000_1FFF);
        chk("multi_lo",  32'h8000_1810, 1, 0, 32'h8000_1000, 32'h8000_1FFF, 8, 1, 1);
        chk("multi_s1",  32'h8000_1310, 1, 1, 32'h8000_1000, 32'h8000_1FFF, 8, 1, 0);
        chk("only_s1",   32'h8000_1990, 1, 1, 32'h8000_1000, 32'h8000_1FFF, 8, 1, 0);

        bus.clear_i = 1'b1;
        wr(32'h8000_3000, 32'h8000_3010);
        bus.clear_i = 1'b0;
        chk("clr_wr_q1", 32'h8000_3000, 0, 0, 0, 0, 0, 0, 0);
        chk("clr_wr_q2", 32'h8000_1810, 0, 0, 0, 0, 0, 0, 0);

        wr(32'hFFFF_FF00, 32'hFFFF_FFFF);
        wr(32'h0000_0000, 32'h0000_0010);
        chk("no_wrap_merge", 32'h0000_0005, 1, 1, 32'h0000_0000, 32'h0000_0010, 2, 0, 0);
        wr(32'h0000_0100, 32'h0000_01FF);
        chk("three", 32'h0000_0105, 1, 2, 32'h0000_0100, 32'h0000_01FF, 3, 0, 0);

        rst_n = 1'b0;
        chk("async_rst", 32'h0000_0105, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        wr(32'h0000_0500, 32'h0000_05FF);
        chk("post_rst", 32'h0000_0510, 1, 0, 32'h0000_0500, 32'h0000_05FF, 1, 0, 0);

        cyc();
        cyc();
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
